memory_controller: RTL and testbench

Responder end of the instruction-fetch request protocol, plus the data port for the LoadStoreBuffer. It takes single-cycle request pulses from the Fetcher (word fetch) and the LSB (1/2/4-byte load or store). It serialises them onto the byte-wide synchronous RAM/IO bus and returns a one-cycle ready pulse with the assembled little-endian result. It also aborts speculative traffic on ROB rollback.

---
 rtl/memory_controller_pkg.sv | 37 +++
 rtl/memory_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_memory_controller.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_pkg.sv
// Shared encodings for the memory controller: request sizes, the IO address
// window and the transfer FSM state.
package memory_controller_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Address bits that select the IO region, and the value that means "IO".
    localparam int         IO_SEL_HI = 17;
    localparam int         IO_SEL_LO = 16;
    localparam logic [1:0] IO_SEL    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Complete transfer-FSM state, kept in one struct so it can be probed as a unit.
    typedef struct packed {
        state_e     state;
        logic       sel_lsb;  // transfer in flight belongs to the LSB port
        logic [2:0] cnt;      // READ: edges since acceptance; WRITE: bytes issued
    } fsm_t;

    // Number of bus bytes for an LSB size code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller.sv
// Serialises Fetcher word fetches and LSB byte/half/word loads and stores onto
// the byte-wide synchronous RAM/IO bus and returns assembled little-endian data.
//
// Handshake: a requester raises *_request_in for exactly one cycle with its
// operands valid in that cycle; the controller remembers it as pending until
// served. Completion is a one-cycle *_ready_out pulse; the matching data
// output is valid in that cycle and holds until that port's next pulse. A
// requester must not pulse again while its previous request is outstanding.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LSB_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_request_in,
    input  logic [ADDR_WIDTH-1:0] if_address_in,
    output logic                  if_ready_out,
    output logic [31:0]           if_instruction_out,
    input  logic                  lsb_request_in,
    input  logic                  lsb_write_in,
    input  logic [1:0]            lsb_size_in,
    input  logic [ADDR_WIDTH-1:0] lsb_address_in,
    input  logic [31:0]           lsb_data_in,
    output logic                  lsb_ready_out,
    output logic [31:0]           lsb_data_out,
    input  logic                  rollback_in,
    input  logic                  io_buffer_full_in,
    input  logic [7:0]            mem_din_in,
    output logic [7:0]            mem_dout_out,
    output logic [ADDR_WIDTH-1:0] mem_a_out,
    output logic                  mem_wr_out
);

    function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
        return a[IO_SEL_HI:IO_SEL_LO] == IO_SEL;
    endfunction

    fsm_t                  fsm_q;
    logic                  if_pending_q, lsb_pending_q;
    logic [ADDR_WIDTH-1:0] if_addr_q, lsb_addr_q;
    logic                  lsb_write_q;
    logic [1:0]            lsb_size_q;
    logic [31:0]           lsb_wdata_q;
    logic [31:0]           rdata_q;
    logic                  if_ready_q, lsb_ready_q, mem_wr_q;
    logic [31:0]           if_instr_q, lsb_rdata_q;
    logic [7:0]            mem_dout_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;

    logic                  if_live_d, lsb_live_d, pick_lsb_d, new_write_d, new_block_d;
    logic [ADDR_WIDTH-1:0] new_addr_d, act_addr_d, rd_addr_d, wr_addr_d;
    logic [2:0]            len_d, cnt_inc_d;
    logic [7:0]            wr_byte_d;
    logic                  wr_block_d;
    logic [1:0]            rd_idx_d;
    logic [31:0]           rdata_d;

    // Arbitration, per-byte addressing and read-data assembly for this cycle.
    always_comb begin
        // A rollback this edge kills pending fetches and loads but never stores.
        if_live_d   = if_pending_q & ~rollback_in;
        lsb_live_d  = lsb_pending_q & ~(rollback_in & ~lsb_write_q);
        pick_lsb_d  = lsb_live_d & ((LSB_PRIORITY != 0) ? 1'b1 : ~if_live_d);
        new_addr_d  = pick_lsb_d ? lsb_addr_q : if_addr_q;
        new_write_d = pick_lsb_d & lsb_write_q;
        new_block_d = is_io(new_addr_d) & io_buffer_full_in;

        len_d       = fsm_q.sel_lsb ? size_bytes(lsb_size_q) : 3'd4;
        act_addr_d  = fsm_q.sel_lsb ? lsb_addr_q : if_addr_q;
        cnt_inc_d   = fsm_q.cnt + 3'd1;
        rd_addr_d   = act_addr_d + ADDR_WIDTH'(cnt_inc_d);
        wr_addr_d   = lsb_addr_q + ADDR_WIDTH'(fsm_q.cnt);
        wr_byte_d   = lsb_wdata_q[{fsm_q.cnt[1:0], 3'b000} +: 8];
        wr_block_d  = is_io(wr_addr_d) & io_buffer_full_in;

        // The byte on mem_din_in now was addressed two edges ago: index cnt-1.
        rd_idx_d    = fsm_q.cnt[1:0] - 2'd1;
        rdata_d     = rdata_q;
        if (fsm_q.cnt != 3'd0) begin
            rdata_d[{rd_idx_d, 3'b000} +: 8] = mem_din_in;
        end
    end

    // Request capture, rollback filtering and the IDLE/READ/WRITE transfer FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q         <= '{state: ST_IDLE, sel_lsb: 1'b0, cnt: 3'd0};
            if_pending_q  <= 1'b0;
            lsb_pending_q <= 1'b0;
            if_addr_q     <= '0;
            lsb_addr_q    <= '0;
            lsb_write_q   <= 1'b0;
            lsb_size_q    <= 2'd0;
            lsb_wdata_q   <= '0;
            rdata_q       <= '0;
            if_ready_q    <= 1'b0;
            lsb_ready_q   <= 1'b0;
            if_instr_q    <= '0;
            lsb_rdata_q   <= '0;
            mem_wr_q      <= 1'b0;
            mem_dout_q    <= '0;
            mem_a_q       <= '0;
        end else begin
            if_ready_q  <= 1'b0;
            lsb_ready_q <= 1'b0;

            if (rollback_in) begin
                if_pending_q <= 1'b0;
                if (!lsb_write_q) begin
                    lsb_pending_q <= 1'b0;
                end
            end

            case (fsm_q.state)
                ST_IDLE: begin
                    if (if_live_d || lsb_live_d) begin
                        fsm_q.sel_lsb <= pick_lsb_d;
                        rdata_q       <= '0;
                        if (new_write_d) begin
                            fsm_q.state <= ST_WRITE;
                            if (new_block_d) begin
                                mem_wr_q  <= 1'b0;
                                mem_a_q   <= '0;
                                fsm_q.cnt <= 3'd0;
                            end else begin
                                mem_wr_q   <= 1'b1;
                                mem_a_q    <= new_addr_d;
                                mem_dout_q <= lsb_wdata_q[7:0];
                                fsm_q.cnt  <= 3'd1;
                            end
                        end else begin
                            fsm_q.state <= ST_READ;
                            mem_wr_q    <= 1'b0;
                            mem_a_q     <= new_addr_d;
                            fsm_q.cnt   <= 3'd0;
                        end
                    end
                end

                ST_READ: begin
                    if (rollback_in) begin
                        // Abort; the byte still in flight from the RAM is dropped.
                        fsm_q.state <= ST_IDLE;
                        fsm_q.cnt   <= 3'd0;
                        mem_a_q     <= '0;
                        mem_wr_q    <= 1'b0;
                    end else begin
                        rdata_q   <= rdata_d;
                        fsm_q.cnt <= cnt_inc_d;
                        mem_a_q   <= (cnt_inc_d < len_d) ? rd_addr_d : '0;
                        if (fsm_q.cnt == len_d) begin
                            fsm_q.state <= ST_IDLE;
                            fsm_q.cnt   <= 3'd0;
                            if (fsm_q.sel_lsb) begin
                                lsb_ready_q   <= 1'b1;
                                lsb_rdata_q   <= rdata_d;
                                lsb_pending_q <= 1'b0;
                            end else begin
                                if_ready_q   <= 1'b1;
                                if_instr_q   <= rdata_d;
                                if_pending_q <= 1'b0;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (fsm_q.cnt == len_d) begin
                        fsm_q.state   <= ST_IDLE;
                        fsm_q.cnt     <= 3'd0;
                        lsb_ready_q   <= 1'b1;
                        lsb_pending_q <= 1'b0;
                        mem_wr_q      <= 1'b0;
                        mem_a_q       <= '0;
                        mem_dout_q    <= '0;
                    end else if (wr_block_d) begin
                        // IO FIFO full: park the bus and retry the same byte.
                        mem_wr_q <= 1'b0;
                        mem_a_q  <= '0;
                    end else begin
                        mem_wr_q   <= 1'b1;
                        mem_a_q    <= wr_addr_d;
                        mem_dout_q <= wr_byte_d;
                        fsm_q.cnt  <= cnt_inc_d;
                    end
                end

                default: begin
                    fsm_q.state <= ST_IDLE;
                    fsm_q.cnt   <= 3'd0;
                    mem_wr_q    <= 1'b0;
                    mem_a_q     <= '0;
                end
            endcase

            // Captures come last so a new pulse wins over a same-edge clear.
            if (if_request_in && !rollback_in) begin
                if_pending_q <= 1'b1;
                if_addr_q    <= if_address_in;
            end
            if (lsb_request_in && !(rollback_in && !lsb_write_in)) begin
                lsb_pending_q <= 1'b1;
                lsb_write_q   <= lsb_write_in;
                lsb_size_q    <= lsb_size_in;
                lsb_addr_q    <= lsb_address_in;
                lsb_wdata_q   <= lsb_data_in;
            end
        end
    end

    assign if_ready_out       = if_ready_q;
    assign if_instruction_out = if_instr_q;
    assign lsb_ready_out      = lsb_ready_q;
    assign lsb_data_out       = lsb_rdata_q;
    assign mem_dout_out       = mem_dout_q;
    assign mem_a_out          = mem_a_q;
    assign mem_wr_out         = mem_wr_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed scoreboard bench for memory_controller: stimulus pushes expected
// ready pulses, bus writes and bus addresses; a negedge monitor pops and compares.
module tb_memory_controller;

    logic        clk;
    logic        rst;
    logic        if_request_in;
    logic [31:0] if_address_in;
    logic        if_ready_out;
    logic [31:0] if_instruction_out;
    logic        lsb_request_in;
    logic        lsb_write_in;
    logic [1:0]  lsb_size_in;
    logic [31:0] lsb_address_in;
    logic [31:0] lsb_data_in;
    logic        lsb_ready_out;
    logic [31:0] lsb_data_out;
    logic        rollback_in;
    logic        io_buffer_full_in;
    logic [7:0]  mem_din_in;
    logic [7:0]  mem_dout_out;
    logic [31:0] mem_a_out;
    logic        mem_wr_out;

    memory_controller #(.ADDR_WIDTH(32), .LSB_PRIORITY(1)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_request_in      (if_request_in),
        .if_address_in      (if_address_in),
        .if_ready_out       (if_ready_out),
        .if_instruction_out (if_instruction_out),
        .lsb_request_in     (lsb_request_in),
        .lsb_write_in       (lsb_write_in),
        .lsb_size_in        (lsb_size_in),
        .lsb_address_in     (lsb_address_in),
        .lsb_data_in        (lsb_data_in),
        .lsb_ready_out      (lsb_ready_out),
        .lsb_data_out       (lsb_data_out),
        .rollback_in        (rollback_in),
        .io_buffer_full_in  (io_buffer_full_in),
        .mem_din_in         (mem_din_in),
        .mem_dout_out       (mem_dout_out),
        .mem_a_out          (mem_a_out),
        .mem_wr_out         (mem_wr_out)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- RAM model (read-only, one-cycle latency) ----------------
    logic [7:0] ram [0:65535];
    always @(posedge clk) mem_din_in <= ram[mem_a_out[15:0]];

    // ---------------- scoreboard ----------------
    // Read ready entry: {cycle[15:0], 15'b0, check_data, data[31:0]}
    // Write entry:      {cycle[15:0], 8'b0, addr[31:0], byte[7:0]}
    logic [63:0] exp_if_q[$];
    logic [63:0] exp_lsb_q[$];
    logic [63:0] exp_wr_q[$];
    logic [31:0] exp_a_at[int];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [63:0] rd_exp(input int cycle, input logic chk, input logic [31:0] data);
        return {16'(cycle), 15'b0, chk, data};
    endfunction

    function automatic logic [63:0] wr_exp(input int cycle, input logic [31:0] addr, input logic [7:0] b);
        return {16'(cycle), 8'b0, addr, b};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d value %08h, none expected", name, cyc, got);
    endtask

    // Monitor: pops an expectation every time the DUT presents an output event.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (!rst) begin
            if (if_ready_out) begin
                if (exp_if_q.size() == 0) unexpected("if_ready", if_instruction_out);
                else begin
                    e = exp_if_q.pop_front();
                    check("if_ready_cycle", 32'(cyc), {16'h0, e[63:48]});
                    if (e[32]) check("if_instruction", if_instruction_out, e[31:0]);
                end
            end
            if (lsb_ready_out) begin
                if (exp_lsb_q.size() == 0) unexpected("lsb_ready", lsb_data_out);
                else begin
                    e = exp_lsb_q.pop_front();
                    check("lsb_ready_cycle", 32'(cyc), {16'h0, e[63:48]});
                    if (e[32]) check("lsb_data", lsb_data_out, e[31:0]);
                end
            end
            if (mem_wr_out) begin
                if (exp_wr_q.size() == 0) unexpected("mem_wr", mem_a_out);
                else begin
                    e = exp_wr_q.pop_front();
                    check("wr_cycle", 32'(cyc), {16'h0, e[63:48]});
                    check("wr_addr", mem_a_out, e[39:8]);
                    check("wr_byte", {24'h0, mem_dout_out}, {24'h0, e[7:0]});
                end
            end
            if (exp_a_at.exists(cyc)) begin
                check("mem_a", mem_a_out, exp_a_at[cyc]);
                exp_a_at.delete(cyc);
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic fetch(input logic [31:0] a, output int t0);
        if_address_in = a;
        if_request_in = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        if_request_in = 1'b0;
    endtask

    task automatic lsb_req(input logic wr, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] d, output int t0);
        lsb_write_in   = wr;
        lsb_size_in    = size;
        lsb_address_in = a;
        lsb_data_in    = d;
        lsb_request_in = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        lsb_request_in = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_if_ready"}, {31'h0, if_ready_out}, 32'h0);
        check({tag, "_if_instr"}, if_instruction_out, 32'h0);
        check({tag, "_lsb_ready"}, {31'h0, lsb_ready_out}, 32'h0);
        check({tag, "_lsb_data"}, lsb_data_out, 32'h0);
        check({tag, "_mem_dout"}, {24'h0, mem_dout_out}, 32'h0);
        check({tag, "_mem_a"}, mem_a_out, 32'h0);
        check({tag, "_mem_wr"}, {31'h0, mem_wr_out}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1;
        rst = 1'b1;
        if_request_in = 1'b0;  if_address_in = '0;
        lsb_request_in = 1'b0; lsb_write_in = 1'b0; lsb_size_in = 2'd0;
        lsb_address_in = '0;   lsb_data_in = '0;
        rollback_in = 1'b0;    io_buffer_full_in = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
        ram[16'h0000] = 8'h11; ram[16'h0001] = 8'h22; ram[16'h0002] = 8'h33; ram[16'h0003] = 8'h44;
        ram[16'h2000] = 8'hEF; ram[16'h2001] = 8'hBE; ram[16'h2002] = 8'hAD; ram[16'h2003] = 8'hDE;
        ram[16'h0200] = 8'h93; ram[16'h0201] = 8'h00; ram[16'h0202] = 8'h10; ram[16'h0203] = 8'h00;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Word fetch with address stepping.
        fetch(32'h1000, t0);
        for (int k = 0; k < 4; k++) exp_a_at[t0 + 1 + k] = 32'h1000 + k;
        exp_a_at[t0 + 5] = 32'h0;
        exp_if_q.push_back(rd_exp(t0 + 6, 1'b1, 32'h0000_0513));
        wait_until(t0 + 9);

        // Simultaneous fetch and LSB word load: LSB first.
        if_address_in = 32'h0;      if_request_in = 1'b1;
        lsb_write_in = 1'b0;        lsb_size_in = 2'd2;
        lsb_address_in = 32'h2000;  lsb_request_in = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        if_request_in = 1'b0; lsb_request_in = 1'b0;
        exp_lsb_q.push_back(rd_exp(t0 + 6, 1'b1, 32'hDEAD_BEEF));
        exp_if_q.push_back(rd_exp(t0 + 12, 1'b1, 32'h4433_2211));
        exp_a_at[t0 + 7] = 32'h0;
        wait_until(t0 + 15);

        // Half store: only low bytes of the store data reach the bus.
        lsb_req(1'b1, 2'd1, 32'h100, 32'h1234_BEEF, t0);
        exp_wr_q.push_back(wr_exp(t0 + 1, 32'h100, 8'hEF));
        exp_wr_q.push_back(wr_exp(t0 + 2, 32'h101, 8'hBE));
        exp_lsb_q.push_back(rd_exp(t0 + 3, 1'b0, 32'h0));
        wait_until(t0 + 6);

        // Byte load with top bit set: zero-extended.
        lsb_req(1'b0, 2'd0, 32'h2003, 32'h0, t0);
        exp_lsb_q.push_back(rd_exp(t0 + 3, 1'b1, 32'h0000_00DE));
        wait_until(t0 + 6);

        // Half load at an odd address.
        lsb_req(1'b0, 2'd1, 32'h2001, 32'h0, t0);
        exp_lsb_q.push_back(rd_exp(t0 + 4, 1'b1, 32'h0000_ADBE));
        wait_until(t0 + 7);

        // IO byte store held off by a full IO FIFO through edge 4.
        io_buffer_full_in = 1'b1;
        lsb_req(1'b1, 2'd0, 32'h3_0000, 32'h0000_00AB, t0);
        exp_wr_q.push_back(wr_exp(t0 + 5, 32'h3_0000, 8'hAB));
        exp_lsb_q.push_back(rd_exp(t0 + 6, 1'b0, 32'h0));
        wait_until(t0 + 4);
        io_buffer_full_in = 1'b0;
        wait_until(t0 + 9);

        // Rollback at edge 3 of a fetch, new fetch pulsed at edge 4.
        fetch(32'h1000, t0);
        exp_a_at[t0 + 2] = 32'h1001;
        exp_a_at[t0 + 3] = 32'h0;
        wait_until(t0 + 2);
        rollback_in = 1'b1;
        @(negedge clk);
        rollback_in = 1'b0;
        fetch(32'h200, t1);
        exp_a_at[t1 + 1] = 32'h200;
        exp_if_q.push_back(rd_exp(t1 + 6, 1'b1, 32'h0010_0093));
        wait_until(t1 + 9);

        // Rollback during a word store, with a fetch pulse in the rollback cycle.
        lsb_req(1'b1, 2'd2, 32'h400, 32'h1122_3344, t0);
        exp_wr_q.push_back(wr_exp(t0 + 1, 32'h400, 8'h44));
        exp_wr_q.push_back(wr_exp(t0 + 2, 32'h401, 8'h33));
        exp_wr_q.push_back(wr_exp(t0 + 3, 32'h402, 8'h22));
        exp_wr_q.push_back(wr_exp(t0 + 4, 32'h403, 8'h11));
        exp_lsb_q.push_back(rd_exp(t0 + 5, 1'b0, 32'h0));
        wait_until(t0 + 1);
        rollback_in = 1'b1;
        if_address_in = 32'h1000;
        if_request_in = 1'b1;
        @(negedge clk);
        if_request_in = 1'b0;
        @(negedge clk);
        rollback_in = 1'b0;
        wait_until(t0 + 12);

        // Reset in the middle of a word load: outputs cleared, no ready.
        lsb_req(1'b0, 2'd2, 32'h2000, 32'h0, t0);
        wait_until(t0 + 2);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        rst = 1'b0;
        wait_until(t0 + 12);

        // Recovery fetch after reset.
        fetch(32'h1000, t0);
        exp_if_q.push_back(rd_exp(t0 + 6, 1'b1, 32'h0000_0513));
        wait_until(t0 + 8);

        // Drain, then anything left unmatched is a miss.
        for (int i = 0; i < 40; i++) begin
            if (exp_if_q.size() == 0 && exp_lsb_q.size() == 0 && exp_wr_q.size() == 0) break;
            @(negedge clk);
        end
        while (exp_if_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL if_ready_missing: expected pulse at cycle %0d never seen", exp_if_q.pop_front() >> 48);
        end
        while (exp_lsb_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL lsb_ready_missing: expected pulse at cycle %0d never seen", exp_lsb_q.pop_front() >> 48);
        end
        while (exp_wr_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL mem_wr_missing: expected write at cycle %0d never seen", exp_wr_q.pop_front() >> 48);
        end
        foreach (exp_a_at[c]) begin
            n_tests++; n_fail++;
            $display("FAIL mem_a_unchecked: cycle %0d expected %08h never sampled", c, exp_a_at[c]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
